// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU operation codes, R-type funct
// values and ALUOp encodings from main control.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_NOR = 3'b100,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // ALUOp from main control; aluop1 high means R-type regardless of aluop0.
  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BEQ   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } aluop_e;

endpackage

// File: rtl/alu_op_decode.sv
// ALU-control decoder: maps ALUOp and the funct field to a 3-bit ALU op.
// Ports: aluop1/aluop0 (ALUOp from main control), funct (instr[5:0]),
//        gout (decoded ALU operation).
module alu_op_decode
  import mips_pkg::*;
(
  input  logic       aluop1,
  input  logic       aluop0,
  input  logic [5:0] funct,
  output logic [2:0] gout
);

  always_comb begin
    gout = ALU_ADD;
    if (aluop1) begin
      case (funct)
        FUNCT_ADD: gout = ALU_ADD;
        FUNCT_SUB: gout = ALU_SUB;
        FUNCT_AND: gout = ALU_AND;
        FUNCT_OR:  gout = ALU_OR;
        FUNCT_NOR: gout = ALU_NOR;
        FUNCT_SLT: gout = ALU_SLT;
        default:   gout = ALU_ADD;
      endcase
    end else if (aluop0) begin
      gout = ALU_SUB;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage arithmetic block: ALU control, 32-bit ALU, PC+4 and branch
// target adders, plus a one-cycle-delayed copy of the result with N/Z/V flags.
// Ports: clk, reset (sync, active high); aluop1/aluop0/funct (control);
//        a/b (operands); pc/offset_sl2 (address adders);
//        gout/sum/zout/pc_plus4/branch_target (combinational);
//        prev_sum/n/z/v (registered status of previous operation).
module alu_exec_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             aluop1,
  input  logic             aluop0,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] offset_sl2,
  output logic [2:0]       gout,
  output logic [WIDTH-1:0] sum,
  output logic             zout,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] prev_sum,
  output logic             n,
  output logic             z,
  output logic             v
);

  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt_bit;
  logic             ovf_c;

  alu_op_decode u_alu_op_decode (
    .aluop1 (aluop1),
    .aluop0 (aluop0),
    .funct  (funct),
    .gout   (gout)
  );

  assign add_res = a + b;
  assign sub_res = a - b;
  assign add_ovf = (a[MSB] == b[MSB]) && (add_res[MSB] != a[MSB]);
  assign sub_ovf = (a[MSB] != b[MSB]) && (sub_res[MSB] != a[MSB]);
  // Sign of a-b corrected by overflow gives the true signed comparison.
  assign slt_bit = sub_res[MSB] ^ sub_ovf;

  always_comb begin
    sum   = '0;
    ovf_c = 1'b0;
    case (gout)
      ALU_ADD: begin
        sum   = add_res;
        ovf_c = add_ovf;
      end
      ALU_SUB: begin
        sum   = sub_res;
        ovf_c = sub_ovf;
      end
      ALU_AND: sum = a & b;
      ALU_OR:  sum = a | b;
      ALU_NOR: sum = ~(a | b);
      ALU_SLT: sum = {{(WIDTH-1){1'b0}}, slt_bit};
      default: sum = '0;
    endcase
  end

  assign zout          = (sum == '0);
  assign pc_plus4      = pc + FOUR;
  assign branch_target = pc_plus4 + offset_sl2;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sum <= '0;
      v        <= 1'b0;
    end else begin
      prev_sum <= sum;
      v        <= ovf_c;
    end
  end

  assign n = prev_sum[MSB];
  assign z = (prev_sum == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic        aluop1, aluop0;
  logic [5:0]  funct;
  logic [31:0] a, b, pc, offset_sl2;
  logic [2:0]  gout;
  logic [31:0] sum, pc_plus4, branch_target, prev_sum;
  logic        zout, n, z, v;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected registered state, tracked from the reference model.
  logic [31:0] exp_prev;
  logic        exp_v;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .aluop1        (aluop1),
    .aluop0        (aluop0),
    .funct         (funct),
    .a             (a),
    .b             (b),
    .pc            (pc),
    .offset_sl2    (offset_sl2),
    .gout          (gout),
    .sum           (sum),
    .zout          (zout),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .prev_sum      (prev_sum),
    .n             (n),
    .z             (z),
    .v             (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation did not finish");
  end

  // Reference model: ALU-control truth table.
  function automatic logic [2:0] ref_gout(input logic o1, input logic o0, input logic [5:0] f);
    if (!o1) return o0 ? 3'b110 : 3'b010;
    case (f)
      6'h20: return 3'b010;
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h27: return 3'b100;
      6'h2A: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [31:0] ref_sum(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint unsigned wide;
    case (op)
      3'b010: begin wide = longint'(x) + longint'(y); return wide[31:0]; end
      3'b110: begin wide = longint'(x) + 64'h1_0000_0000 - longint'(y); return wide[31:0]; end
      3'b000: return x & y;
      3'b001: return x | y;
      3'b100: return ~(x | y);
      3'b111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Overflow: true mathematical signed result falls outside the 32-bit range.
  function automatic logic ref_ovf(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint s;
    if (op == 3'b010)      s = longint'($signed(x)) + longint'($signed(y));
    else if (op == 3'b110) s = longint'($signed(x)) - longint'($signed(y));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one operation on the falling edge and check combinational outputs.
  task automatic drive(input logic o1, input logic o0, input logic [5:0] f,
                       input logic [31:0] av, input logic [31:0] bv);
    logic [2:0]  eg;
    logic [31:0] es;
    @(negedge clk);
    aluop1 = o1; aluop0 = o0; funct = f; a = av; b = bv;
    #1;
    eg = ref_gout(o1, o0, f);
    es = ref_sum(eg, av, bv);
    chk("gout", {29'd0, gout}, {29'd0, eg});
    chk("sum", sum, es);
    chk("zout", {31'd0, zout}, {31'd0, es == 32'd0});
    if (!reset) begin
      exp_prev = es;
      exp_v    = ref_ovf(eg, av, bv);
    end
  endtask

  // Advance one rising edge and check the status register.
  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) begin
      exp_prev = 32'd0;
      exp_v    = 1'b0;
    end
    chk("prev_sum", prev_sum, exp_prev);
    chk("n", {31'd0, n}, {31'd0, exp_prev[31]});
    chk("z", {31'd0, z}, {31'd0, exp_prev == 32'd0});
    chk("v", {31'd0, v}, {31'd0, exp_v});
  endtask

  task automatic adders(input logic [31:0] p, input logic [31:0] o);
    longint unsigned t;
    @(negedge clk);
    pc = p; offset_sl2 = o;
    #1;
    t = longint'(p) + 64'd4;
    chk("pc_plus4", pc_plus4, t[31:0]);
    t = longint'(p) + 64'd4 + longint'(o);
    chk("branch_target", branch_target, t[31:0]);
  endtask

  logic [5:0] funct_tbl [7];
  logic [31:0] edge_tbl [6];

  initial begin
    funct_tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};
    edge_tbl  = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0001};
    reset = 1'b1; aluop1 = 0; aluop0 = 0; funct = 0;
    a = 0; b = 0; pc = 0; offset_sl2 = 0;
    exp_prev = 0; exp_v = 0;

    // Reset state.
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;

    // ALU-control coverage.
    drive(0, 0, 6'h00, 32'd10, 32'd4);
    drive(0, 1, 6'h00, 32'd10, 32'd4);
    for (int unsigned i = 0; i < 7; i++) drive(1, 0, funct_tbl[i], 32'd10, 32'd4);

    // Directed arithmetic.
    drive(1, 0, 6'h20, 32'd5, 32'd3);
    drive(1, 0, 6'h22, 32'd3, 32'd3);
    tick();
    drive(1, 0, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0);
    drive(1, 0, 6'h25, 32'hF0F0F0F0, 32'h0FF00FF0);
    drive(1, 0, 6'h27, 32'hF0F0F0F0, 32'h0FF00FF0);

    // SLT extremes.
    drive(1, 0, 6'h2A, 32'h80000000, 32'h7FFFFFFF);
    drive(1, 0, 6'h2A, 32'h7FFFFFFF, 32'h80000000);
    drive(1, 0, 6'h2A, 32'hFFFFFFFF, 32'h00000001);

    // Overflow into status flags.
    drive(1, 0, 6'h20, 32'h7FFFFFFF, 32'h00000001);
    tick();
    drive(1, 0, 6'h22, 32'h80000000, 32'h00000001);
    tick();

    // Adders.
    adders(32'h0, 32'h8);
    adders(32'hFFFFFFFC, 32'hFFFFFFF8);
    for (int unsigned i = 0; i < 8; i++) adders($urandom, $urandom);

    // Reset mid-stream with a live sum of 1234.
    drive(0, 0, 6'h00, 32'd1234, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 6'h00, 32'd1234, 32'd0);
    tick();

    // Randomized operations, biased toward edge operands.
    for (int unsigned i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      logic [5:0]  rf;
      ra = ($urandom_range(0, 2) == 0) ? edge_tbl[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? edge_tbl[$urandom_range(0, 5)] : $urandom;
      rf = ($urandom_range(0, 4) == 0) ? 6'($urandom) : funct_tbl[$urandom_range(0, 6)];
      drive(1'($urandom), 1'($urandom), rf, ra, rb);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic block for the single-cycle MIPS datapath. It contains three parts:
- the ALU-control decoder, which turns ALUOp plus the funct field into a 3-bit ALU operation;
- the 32-bit ALU;
- the two address adders, PC+4 and branch target.

It also holds a one-cycle-delayed copy of the ALU result and its N/Z/V status flags. The status-based jump/branch logic consumes those flags in the following cycle.

## Interface
Parameters:
- WIDTH, 32, datapath width; only 32 is required to be supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- aluop1  input  1  ALUOp bit 1 from main control.
- aluop0  input  1  ALUOp bit 0 from main control.
- funct  input  6  instruction bits [5:0].
- a  input  32  ALU operand A (register Read data 1).
- b  input  32  ALU operand B (output of the ALUSrc mux).
- pc  input  32  current program counter.
- offset_sl2  input  32  sign-extended immediate shifted left by 2.
- gout  output  3  decoded ALU operation.
- sum  output  32  ALU result, combinational.
- zout  output  1  high when sum == 0, combinational.
- pc_plus4  output  32  pc + 4, combinational.
- branch_target  output  32  pc_plus4 + offset_sl2, combinational.
- prev_sum  output  32  registered copy of sum.
- n  output  1  registered sign flag, prev_sum[31].
- z  output  1  registered zero flag, prev_sum == 0.
- v  output  1  registered signed-overflow flag of the previous operation.

## Operation
ALU control decode (gout):
- aluop1=0, aluop0=0 → 010 (add; loads and stores).
- aluop1=0, aluop0=1 → 110 (subtract; beq).
- aluop1=1 (R-type), selected by funct:
  - 100000 → 010 add
  - 100010 → 110 sub
  - 100100 → 000 and
  - 100101 → 001 or
  - 100111 → 100 nor
  - 101010 → 111 slt
  - any other funct → 010.

ALU (sum), per gout:
- 010: a + b, modulo 2^32.
- 110: a − b, modulo 2^32.
- 000: a & b.
- 001: a | b.
- 100: ~(a | b).
- 111: 32'd1 if signed(a) < signed(b), else 0. Computed from the subtraction sign XOR its overflow, so it is correct at extremes.
- Unused codes 011 and 101: sum = 0.

zout = (sum == 0), independent of operation.

Overflow, computed combinationally (ovf_c):
- add: high when both operand signs are equal and the result sign differs.
- sub: high when the operand signs differ and the result sign differs from a.
- all other operations: 0.

Adders:
- pc_plus4 = pc + 4, wrapping.
- branch_target = pc_plus4 + offset_sl2, wrapping. Carries are discarded.

Status register:
- Every rising clk edge: prev_sum ← sum; v ← ovf_c.
- n and z are derived from prev_sum, or registered so they are equivalent.
- Reset clears prev_sum, n, z and v to 0. Exception: z reads 1 after reset, because prev_sum == 0.

## Timing
- gout, sum, zout, pc_plus4 and branch_target are purely combinational from the inputs; zero latency.
- prev_sum, n, z and v have a latency of exactly one cycle: the value present before edge k is visible after edge k.
- Reset is synchronous. If reset is high at an edge, state goes to the reset values and the current sum is discarded. The combinational outputs are unaffected by reset.
- Reset asserted mid-stream: the first capture after deassertion is the sum present at the first edge with reset low.
- No handshake; the status register captures on every non-reset cycle.

## Structure
Shared package (mips_pkg):
- ALU operation codes: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_NOR=3'b100, ALU_SUB=3'b110, ALU_SLT=3'b111.
- funct constants.
- ALUOp encodings.

Sub-modules:
- One sub-module, alu_op_decode: aluop1/aluop0/funct → gout.
- The ALU, both adders and the status register are inline in alu_exec_unit.

## Test plan
- ALU-control coverage: aluop1:aluop0 = 00 → gout 010; 01 → 110. With 10 and funct 20/22/24/25/27/2A (hex) → gout 010/110/000/001/100/111. Funct 3F → 010.
- Arithmetic:
  - a=5, b=3, R-type add → sum 8, zout 0.
  - R-type sub with a=3, b=3 → sum 0, zout 1.
  - R-type and, or and nor with a=F0F0F0F0, b=0FF00FF0 → sum 00F000F0, FFF0FFF0, 000F000F respectively.
- SLT edge cases:
  - a=80000000, b=7FFFFFFF → sum 1.
  - a=7FFFFFFF, b=80000000 → sum 0.
  - a=FFFFFFFF, b=1 → sum 1.
- Overflow and status flags:
  - add 7FFFFFFF+1 → sum 80000000 combinationally.
  - After the next rising edge: prev_sum 80000000, n=1, z=0, v=1.
  - Then sub 80000000−1 → after the edge: prev_sum 7FFFFFFF, n=0, v=1.
- Adders:
  - pc=0, offset_sl2=8 → pc_plus4 4, branch_target C.
  - pc=FFFFFFFC, offset_sl2=FFFFFFF8 → pc_plus4 0, branch_target FFFFFFF8.
- Reset:
  - Hold reset=1 for 2 edges while sum=1234 → prev_sum 0, z=1, n=0, v=0.
  - Deassert reset → the next edge captures 1234.
